// File: rtl/tsf64_reader_pkg.sv
// Shared IPIC and ath9k definitions, plus the TSF reader state encoding.
package tsf64_reader_pkg;

  // IPIC lite dispatcher request type codes
  localparam logic [2:0] IPIC_SINGLE_RD = 3'd2;
  localparam logic [2:0] IPIC_SINGLE_WR = 3'd3;

  // ath9k TSF register bus addresses
  localparam logic [31:0] AR_TSF_L32 = 32'h0000_804C;
  localparam logic [31:0] AR_TSF_U32 = 32'h0000_8050;

  // TSF reader FSM encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ISSUE_HI1 = 4'd1;
  localparam logic [3:0] ST_WAIT_HI1  = 4'd2;
  localparam logic [3:0] ST_ISSUE_LO  = 4'd3;
  localparam logic [3:0] ST_WAIT_LO   = 4'd4;
  localparam logic [3:0] ST_ISSUE_HI2 = 4'd5;
  localparam logic [3:0] ST_WAIT_HI2  = 4'd6;
  localparam logic [3:0] ST_CHECK     = 4'd7;
  localparam logic [3:0] ST_DRAIN     = 4'd8;

  function automatic logic st_is_issue(input logic [3:0] st);
    return (st == ST_ISSUE_HI1) || (st == ST_ISSUE_LO) || (st == ST_ISSUE_HI2);
  endfunction

  function automatic logic st_is_wait(input logic [3:0] st);
    return (st == ST_WAIT_HI1) || (st == ST_WAIT_LO) || (st == ST_WAIT_HI2);
  endfunction

endpackage

// File: rtl/tsf64_reader_if.sv
// Request/response bus between the TSF reader and the IPIC lite dispatcher.
//
// Handshake: ipic_start is a one-cycle request qualified by ipic_type and
// read_addr; the dispatcher answers some cycles later with a one-cycle
// ipic_done, and single_read_data is valid from that cycle on. There is no
// backpressure: the master never raises a second ipic_start before the
// ipic_done of the first, and holds read_addr stable from start to done.
interface tsf64_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [2:0]            ipic_type;
  logic                  ipic_start;
  logic                  ipic_done;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] single_read_data;

  modport master (
    output ipic_type, ipic_start, read_addr, write_addr, write_data,
    input  ipic_done, single_read_data
  );

  modport slave (
    input  ipic_type, ipic_start, read_addr, write_addr, write_data,
    output ipic_done, single_read_data
  );
endinterface

// File: rtl/tsf64_reader.sv
// Reads the 64-bit ath9k TSF as upper, lower, upper over the IPIC dispatcher
// and retries the lower/upper pair when the upper word rolled over.
module tsf64_reader
  import tsf64_reader_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] TSF_L32_ADDR   = ADDR_WIDTH'(AR_TSF_L32),
  parameter logic [ADDR_WIDTH-1:0] TSF_U32_ADDR   = ADDR_WIDTH'(AR_TSF_U32),
  parameter int                    MAX_RETRY      = 3,
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  output logic                    busy,
  output logic                    tsf_valid,
  output logic [2*DATA_WIDTH-1:0] tsf,
  output logic                    err,
  tsf64_reader_if.master          bus,
  output logic [3:0]              state_dbg
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [3:0]            state;
  logic [3:0]            state_next;
  logic [RW-1:0]         retry_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] hi1;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] hi2;
  logic                  tmo_hit;

  // The counter is 0 in the first WAIT cycle, so the err pulse registered on
  // the edge that would take it to TIMEOUT_CYCLES-1 lands exactly
  // TIMEOUT_CYCLES cycles after the start. A done in that cycle wins.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 2)) && !bus.ipic_done;

  assign busy           = (state != ST_IDLE);
  assign state_dbg      = state;
  assign bus.ipic_start = st_is_issue(state);
  assign bus.ipic_type  = IPIC_SINGLE_RD;
  assign bus.write_addr = '0;
  assign bus.write_data = '0;

  // Next-state decode; only one dispatcher request is ever outstanding.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (req) state_next = ST_ISSUE_HI1;
      ST_ISSUE_HI1: state_next = ST_WAIT_HI1;
      ST_WAIT_HI1: begin
        if (bus.ipic_done)  state_next = ST_ISSUE_LO;
        else if (tmo_hit)   state_next = ST_DRAIN;
      end
      ST_ISSUE_LO:  state_next = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (bus.ipic_done)  state_next = ST_ISSUE_HI2;
        else if (tmo_hit)   state_next = ST_DRAIN;
      end
      ST_ISSUE_HI2: state_next = ST_WAIT_HI2;
      ST_WAIT_HI2: begin
        if (bus.ipic_done)  state_next = ST_CHECK;
        else if (tmo_hit)   state_next = ST_DRAIN;
      end
      // A mismatch re-reads only the lower word and the new upper word,
      // treating the last upper read as the new reference.
      ST_CHECK: begin
        if (hi2 == hi1)                  state_next = ST_IDLE;
        else if (retry_cnt < RW'(MAX_RETRY)) state_next = ST_ISSUE_LO;
        else                             state_next = ST_IDLE;
      end
      // A timed-out request may still complete; swallow its done here so it
      // cannot be mistaken for the response to a later request.
      ST_DRAIN:     if (bus.ipic_done) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State, captured words, counters and result/pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      tsf_valid     <= 1'b0;
      err           <= 1'b0;
      tsf           <= '0;
      bus.read_addr <= '0;
      retry_cnt     <= '0;
      tmo_cnt       <= '0;
      hi1           <= '0;
      lo            <= '0;
      hi2           <= '0;
    end else begin
      state     <= state_next;
      tsf_valid <= 1'b0;
      err       <= 1'b0;

      if (st_is_issue(state_next))
        bus.read_addr <= (state_next == ST_ISSUE_LO) ? TSF_L32_ADDR : TSF_U32_ADDR;

      if (st_is_issue(state))
        tmo_cnt <= '0;
      else if (st_is_wait(state))
        tmo_cnt <= tmo_cnt + TW'(1);

      case (state)
        ST_IDLE: if (req) retry_cnt <= '0;
        ST_WAIT_HI1: begin
          if (bus.ipic_done) hi1 <= bus.single_read_data;
          else if (tmo_hit)  err <= 1'b1;
        end
        ST_WAIT_LO: begin
          if (bus.ipic_done) lo <= bus.single_read_data;
          else if (tmo_hit)  err <= 1'b1;
        end
        ST_WAIT_HI2: begin
          if (bus.ipic_done) hi2 <= bus.single_read_data;
          else if (tmo_hit)  err <= 1'b1;
        end
        ST_CHECK: begin
          if (hi2 == hi1) begin
            tsf       <= {hi2, lo};
            tsf_valid <= 1'b1;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            hi1       <= hi2;
            retry_cnt <= retry_cnt + RW'(1);
          end else begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tsf64_reader.sv
// Directed bench for tsf64_reader: vector table plus hand-written sequences
// for timeout, held req and mid-operation reset.
module tb_tsf64_reader;
  import tsf64_reader_pkg::*;

  localparam int TIMEOUT = 4096;
  localparam int NV      = 7;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        busy;
  logic        tsf_valid;
  logic [63:0] tsf;
  logic        err;
  logic [3:0]  state_dbg;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tsf64_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  tsf64_reader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TSF_L32_ADDR(32'h0000_804C), .TSF_U32_ADDR(32'h0000_8050),
    .MAX_RETRY(3), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .busy(busy),
    .tsf_valid(tsf_valid), .tsf(tsf), .err(err), .bus(bus),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_q[$];
  logic [31:0] lo_q[$];
  logic [63:0] model_tsf = '0;
  int n_start, n_valid, n_err, first_start_cyc, evt_cyc, req_cyc, idle_cyc;
  bit addr_bad, overlap_bad, wr_bad;
  int dly = 1;
  int dly_once = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- dispatcher model ----------------
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr, pend_data;

  initial begin
    bus.ipic_done = 1'b0;
    bus.single_read_data = '0;
  end

  // Done is raised for the cycle D cycles after the start cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
      pend_cnt = 0;
      bus.ipic_done = 1'b0;
    end else begin
      bus.ipic_done = 1'b0;
      if (pend) begin
        if (bus.read_addr !== pend_addr) addr_bad = 1'b1;
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.ipic_done = 1'b1;
          bus.single_read_data = pend_data;
          pend = 1'b0;
        end
      end
      if (bus.ipic_start) begin
        if (pend) overlap_bad = 1'b1;
        pend = 1'b1;
        pend_addr = bus.read_addr;
        pend_cnt = (dly_once > 0) ? dly_once : dly;
        dly_once = 0;
        if (bus.read_addr == AR_TSF_U32)
          pend_data = (hi_q.size() > 0) ? hi_q.pop_front() : 32'h0;
        else if (bus.read_addr == AR_TSF_L32)
          pend_data = (lo_q.size() > 0) ? lo_q.pop_front() : 32'h0;
        else begin
          addr_bad = 1'b1;
          pend_data = 32'h0;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ipic_start) begin
        if (n_start == 0) first_start_cyc = cyc;
        n_start++;
      end
      if (err) begin
        n_err++;
        evt_cyc = cyc;
      end
      if (tsf_valid) begin
        n_valid++;
        evt_cyc = cyc;
        if (exp_q.size() == 0) chk("tsf_valid_unexpected", 64'd1, 64'd0);
        else chk("tsf_on_valid", tsf, exp_q.pop_front());
      end
      if (bus.write_addr !== '0 || bus.write_data !== '0 || bus.ipic_type !== IPIC_SINGLE_RD)
        wr_bad = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    n_start = 0; n_valid = 0; n_err = 0;
    first_start_cyc = -1; evt_cyc = -1; idle_cyc = -1;
    addr_bad = 1'b0; overlap_bad = 1'b0; wr_bad = 1'b0;
    hi_q.delete(); lo_q.delete();
  endtask

  task automatic load(input int nhi, input logic [0:4][31:0] hi,
                      input int nlo, input logic [0:3][31:0] lo);
    for (int k = 0; k < nhi; k++) hi_q.push_back(hi[k]);
    for (int k = 0; k < nlo; k++) lo_q.push_back(lo[k]);
  endtask

  // One-cycle req pulse, then wait (bounded) for busy to drop.
  task automatic run_req(input string name, input int bound);
    bit ok = 1'b0;
    @(posedge clk); #1; req = 1'b1; req_cyc = cyc;
    @(posedge clk); #1; req = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #2;
      if (!busy) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    chk({name, "_busy_release"}, {63'd0, ok}, 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_tsf_valid"}, {63'd0, tsf_valid}, 64'd0);
    chk({name, "_err"}, {63'd0, err}, 64'd0);
    chk({name, "_tsf"}, tsf, 64'd0);
    chk({name, "_start"}, {63'd0, bus.ipic_start}, 64'd0);
    chk({name, "_read_addr"}, {32'd0, bus.read_addr}, 64'd0);
    chk({name, "_type"}, {61'd0, bus.ipic_type}, 64'd2);
    chk({name, "_state"}, {60'd0, state_dbg}, {60'd0, ST_IDLE});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string             name;
    int                d;
    int                nhi;
    logic [0:4][31:0]  hi;
    int                nlo;
    logic [0:3][31:0]  lo;
    int                starts;
    bit                ok;
    logic [63:0]       tsf;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input string name, input int d, input int nhi,
                              input logic [0:4][31:0] hi, input int nlo,
                              input logic [0:3][31:0] lo, input int starts,
                              input bit ok, input logic [63:0] t);
    vec_t v;
    v.name = name; v.d = d; v.nhi = nhi; v.hi = hi; v.nlo = nlo; v.lo = lo;
    v.starts = starts; v.ok = ok; v.tsf = t;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int exp_lat;

    vecs[0] = mk("basic", 5, 3, {32'h1, 32'h1, 32'h0, 32'h0, 32'h0},
                 1, {32'h89AB_CDEF, 32'h0, 32'h0, 32'h0}, 3, 1'b1, 64'h0000_0001_89AB_CDEF);
    vecs[1] = mk("rollover", 2, 3, {32'h5, 32'h6, 32'h6, 32'h0, 32'h0},
                 2, {32'hFFFF_FFF0, 32'h2, 32'h0, 32'h0}, 5, 1'b1, 64'h0000_0006_0000_0002);
    vecs[2] = mk("retry_exhaust", 1, 5, {32'd10, 32'd11, 32'd12, 32'd13, 32'd14},
                 4, {32'd20, 32'd21, 32'd22, 32'd23}, 9, 1'b0, 64'h0);
    vecs[3] = mk("all_ones", 1, 2, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0},
                 1, {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[4] = mk("zero", 3, 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 1, {32'h0, 32'h0, 32'h0, 32'h0}, 3, 1'b1, 64'h0);
    vecs[5] = mk("two_retries", 7, 4, {32'h7, 32'h8, 32'h9, 32'h9, 32'h0},
                 3, {32'hFFFF_FFFF, 32'h0, 32'h5, 32'h0}, 7, 1'b1, 64'h0000_0009_0000_0005);
    vecs[6] = mk("max_retry_match", 4, 5, {32'h1, 32'h2, 32'h3, 32'h4, 32'h4},
                 4, {32'hA, 32'hB, 32'hC, 32'hD}, 9, 1'b1, 64'h0000_0004_0000_000D);

    clear_sb();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Table: each record is one request; latency counts req-set cycle to pulse.
    for (int i = 0; i < NV; i++) begin
      clear_sb();
      dly = vecs[i].d;
      load(vecs[i].nhi, vecs[i].hi, vecs[i].nlo, vecs[i].lo);
      if (vecs[i].ok) exp_q.push_back(vecs[i].tsf);
      run_req(vecs[i].name, 1000);
      if (vecs[i].ok) model_tsf = vecs[i].tsf;
      exp_lat = vecs[i].starts * (vecs[i].d + 1) + (vecs[i].starts - 1) / 2 + 1;
      chk({vecs[i].name, "_starts"}, n_start, vecs[i].starts);
      chk({vecs[i].name, "_valid_cnt"}, n_valid, vecs[i].ok ? 1 : 0);
      chk({vecs[i].name, "_err_cnt"}, n_err, vecs[i].ok ? 0 : 1);
      chk({vecs[i].name, "_tsf"}, tsf, model_tsf);
      chk({vecs[i].name, "_latency"}, evt_cyc - req_cyc, exp_lat);
      chk({vecs[i].name, "_bus_rules"}, {61'd0, addr_bad, overlap_bad, wr_bad}, 64'd0);
      chk({vecs[i].name, "_sb_empty"}, exp_q.size(), 0);
    end

    // Done arriving in the very cycle the timeout would fire: done wins.
    clear_sb();
    dly = 2; dly_once = TIMEOUT - 1;
    load(2, {32'h3, 32'h3, 32'h0, 32'h0, 32'h0}, 1, {32'h1234, 32'h0, 32'h0, 32'h0});
    exp_q.push_back(64'h0000_0003_0000_1234);
    run_req("done_wins", 6000);
    model_tsf = 64'h0000_0003_0000_1234;
    chk("done_wins_err_cnt", n_err, 0);
    chk("done_wins_valid_cnt", n_valid, 1);
    chk("done_wins_tsf", tsf, model_tsf);

    // Done withheld past the timeout: err, then drain until the late done.
    clear_sb();
    dly = 2; dly_once = 5000;
    load(1, {32'hEEEE_0000, 32'h0, 32'h0, 32'h0, 32'h0}, 0, {32'h0, 32'h0, 32'h0, 32'h0});
    run_req("timeout", 6000);
    chk("timeout_err_cnt", n_err, 1);
    chk("timeout_err_cycle", evt_cyc - first_start_cyc, TIMEOUT);
    chk("timeout_busy_drop", idle_cyc - first_start_cyc, 5001);
    chk("timeout_valid_cnt", n_valid, 0);
    chk("timeout_starts", n_start, 1);
    chk("timeout_tsf", tsf, model_tsf);

    clear_sb();
    load(2, {32'h2, 32'h2, 32'h0, 32'h0, 32'h0}, 1, {32'h55, 32'h0, 32'h0, 32'h0});
    exp_q.push_back(64'h0000_0002_0000_0055);
    run_req("after_timeout", 1000);
    model_tsf = 64'h0000_0002_0000_0055;
    chk("after_timeout_valid_cnt", n_valid, 1);
    chk("after_timeout_tsf", tsf, model_tsf);
    chk("after_timeout_latency", evt_cyc - req_cyc, 3 * 3 + 2);

    // req held high, dropped and re-raised mid-read: still one transaction.
    clear_sb();
    dly = 3;
    load(2, {32'h1, 32'h1, 32'h0, 32'h0, 32'h0}, 1, {32'hABC, 32'h0, 32'h0, 32'h0});
    exp_q.push_back(64'h0000_0001_0000_0ABC);
    @(posedge clk); #1; req = 1'b1; req_cyc = cyc;
    repeat (5) @(posedge clk);
    #1; req = 1'b0;
    @(posedge clk); #1; req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (tsf_valid) begin
        req = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    chk("held_req_valid_seen", {63'd0, ok}, 64'd1);
    repeat (10) @(posedge clk);
    #2;
    model_tsf = 64'h0000_0001_0000_0ABC;
    chk("held_req_starts", n_start, 3);
    chk("held_req_valid_cnt", n_valid, 1);
    chk("held_req_latency", evt_cyc - req_cyc, 3 * 4 + 2);
    chk("held_req_bus_rules", {61'd0, addr_bad, overlap_bad, wr_bad}, 64'd0);
    chk("held_req_busy", {63'd0, busy}, 64'd0);

    // Reset while waiting on the lower word.
    clear_sb();
    dly = 10;
    load(2, {32'h7, 32'h7, 32'h0, 32'h0, 32'h0}, 1, {32'h8, 32'h0, 32'h0, 32'h0});
    @(posedge clk); #1; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (state_dbg == ST_WAIT_LO) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reset_reached_wait_lo", {63'd0, ok}, 64'd1);
    reset_n = 1'b0;
    @(posedge clk); #2;
    chk_reset_vals("mid_reset");
    reset_n = 1'b1;
    model_tsf = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    clear_sb();
    dly = 2;
    load(2, {32'h4, 32'h4, 32'h0, 32'h0, 32'h0}, 1, {32'h9, 32'h0, 32'h0, 32'h0});
    exp_q.push_back(64'h0000_0004_0000_0009);
    run_req("after_reset", 1000);
    chk("after_reset_starts", n_start, 3);
    chk("after_reset_tsf", tsf, 64'h0000_0004_0000_0009);
    chk("after_reset_latency", evt_cyc - req_cyc, 3 * 3 + 2);

    // ---------------- final report ----------------
    chk("sb_final_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
